bcd_timer_ctrl: RTL
===================

Name: bcd_timer_ctrl

Overview:
Multi-digit BCD timer controller that sequences a cascade of decade counters, one per decimal digit, from a single command interface.
- Accepts LOAD/START/STOP/CLEAR commands via valid/ready.
- Prescales the clock into count ticks.
- Ripples borrow/carry across digits.
- Reports expiry (count-down reaching 0) or wrap (count-up rolling past all-9s).
- Sits between software-facing control logic and the digit display/decode path.

Parameters:
- DIGITS, 4, number of BCD digits (>=1).
- PRESCALE, 10, clock cycles per count tick (>=2).
- PW, 8, prescaler counter width; must hold PRESCALE-1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accept; constant 1 except during reset (0 while reset=1).
- cmd_op  in  2  0=LOAD, 1=START, 2=STOP, 3=CLEAR.
- cmd_up  in  1  direction latched on START: 1=up, 0=down.
- cmd_data  in  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- count  out  4*DIGITS  current BCD value.
- running  out  1  high in RUN state.
- tick  out  1  one-cycle prescaler strobe (RUN only).
- expired  out  1  one-cycle pulse on count-down reaching 0.
- wrapped  out  1  one-cycle pulse on count-up rollover.
- cmd_err  out  1  one-cycle pulse on rejected command.

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE; count=0; prescaler=0; dir=down.
  - running, tick, expired, wrapped, cmd_err all 0.
  - Reset overrides everything, including mid-RUN.
- States: IDLE, RUN, PAUSE, DONE.
- Accept = cmd_valid & cmd_ready. Unaccepted cycles change nothing.
- LOAD:
  - Legal in IDLE, PAUSE, DONE. Writes count from cmd_data; next state IDLE; prescaler=0.
  - Any nibble >9 is clamped to 9, per digit.
  - In RUN: rejected; cmd_err pulses next cycle; count unchanged.
- START:
  - Legal in IDLE, PAUSE, DONE. Latches dir=cmd_up.
  - From IDLE/DONE: prescaler=0. From PAUSE: prescaler keeps its value, so the run resumes.
  - Next state RUN; running=1 from the next cycle.
  - Down-direction START with count==0: goes to DONE instead of RUN, and expired pulses next cycle.
  - In RUN: rejected with cmd_err.
- STOP:
  - RUN -> PAUSE; count and prescaler frozen.
  - STOP in any other state is a no-op (no error).
- CLEAR: legal in all states. count=0, prescaler=0, state IDLE.
- Prescaler:
  - In RUN, increments each cycle. tick=1 combinationally when prescaler==PRESCALE-1 and state==RUN and no STOP/CLEAR is accepted that cycle.
  - On tick, prescaler returns to 0. The count update appears at the same edge.
  - Latency: START accepted in cycle N -> first tick in cycle N+PRESCALE -> new count visible at N+PRESCALE+1.
- Down count on tick:
  - Digit 0 decrements. A digit at 0 borrows: it becomes 9 and the next digit decrements.
  - Result all-zero -> state DONE and expired=1 in the cycle the zero count is visible.
  - Never underflows; DONE holds at 0 (saturate).
- Up count on tick:
  - Digit 0 increments. A digit at 9 carries: it becomes 0 and the next digit increments.
  - All-9s -> all-0, wrapped=1 with the zero visible; state stays RUN.
- Simultaneous events: an accepted command in a tick cycle takes priority; the tick is suppressed and the count is not stepped.
- Pulse outputs (expired, wrapped, cmd_err) are registered, one cycle wide, and never asserted during or directly after reset.

Decomposition:
- Shared package bcd_timer_pkg holds:
  - cmd_op enum: OP_LOAD, OP_START, OP_STOP, OP_CLEAR.
  - state enum: S_IDLE, S_RUN, S_PAUSE, S_DONE.
  - Constant BCD_MAX=4'd9.
- One sub-module, bcd_digit (generated DIGITS times):
  - Inputs: load, clr, step, up, borrow/carry-in, 4-bit data.
  - Outputs: digit value and carry/borrow-out. carry-out when up & value==9 & step; borrow-out when !up & value==0 & step.
  - A controller-level all-zero detect gates saturation.

Test Plan (DIGITS=2, PRESCALE=3):
1. Reset mid-RUN with count=0x37 -> next cycle count=0x00, running=0, no expired/cmd_err pulse.
2. LOAD 0x10, START down at cycle N -> ticks at N+3 and N+6; count 0x09 visible at N+4 (borrow), 0x08 at N+7; running=1 from N+1.
3. LOAD 0x01, START down -> after one tick count=0x00, state DONE, expired pulses exactly once; further cycles keep count 0x00 with no tick.
4. LOAD 0x98, START up -> 0x99, then 0x00 with wrapped=1 for one cycle; running stays 1.
5. LOAD 0x3C -> count=0x39 (nibble clamp). LOAD while RUN -> cmd_err pulse, count unchanged.
6. RUN, STOP accepted on the tick cycle -> no tick, count frozen; START after 5 idle cycles resumes with prescaler preserved. CLEAR in PAUSE -> count 0x00, IDLE. Down START at 0x00 -> DONE plus expired next cycle.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD timer controller.
//   cmd_op_e : command opcodes on the command interface
//   state_e  : controller states
//   BCD_MAX  : largest legal BCD digit
//   bcd_clamp: forces an illegal nibble (>9) to 9
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_START = 2'd1,
        OP_STOP  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Command interface for the BCD timer controller.
//   cmd_valid / cmd_ready : handshake, a command is taken when both are high
//   cmd_op                : LOAD / START / STOP / CLEAR
//   cmd_up                : count direction, latched on START
//   cmd_data              : BCD load value, digit 0 in bits [3:0]
interface bcd_timer_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    import bcd_timer_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    cmd_op_e             cmd_op;
    logic                cmd_up;
    logic [4*DIGITS-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_up,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_up,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/bcd_digit.sv
// One decade counter of the BCD cascade.
//   clock, reset : system clock, synchronous active-high reset
//   load, data   : write the (clamped) BCD nibble
//   clr          : force the digit to 0 (wins over load)
//   step, up     : count tick and direction
//   cin          : lower digits all carried/borrowed (1 for digit 0)
//   value        : current digit
//   cout         : this digit carries (up, at 9) or borrows (down, at 0) on this step
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       clr,
    input  logic       step,
    input  logic       up,
    input  logic       cin,
    input  logic [3:0] data,
    output logic [3:0] value,
    output logic       cout
);

    logic [3:0] value_q, value_d;
    logic       at_edge;

    always_comb begin
        at_edge = up ? (value_q == BCD_MAX) : (value_q == 4'd0);
        cout    = step & cin & at_edge;
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (load) begin
            value_d = bcd_clamp(data);
        end else if (step && cin) begin
            if (up) begin
                value_d = at_edge ? 4'd0 : value_q + 4'd1;
            end else begin
                value_d = at_edge ? BCD_MAX : value_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Multi-digit BCD timer controller: command decode, prescaler and a cascade of
// bcd_digit counters.
//   clock, reset : system clock, synchronous active-high reset
//   cmd          : command interface (slave side)
//   count        : current BCD value, digit 0 in bits [3:0]
//   running      : controller is in RUN
//   tick         : prescaler strobe, count steps at the end of this cycle
//   expired      : one-cycle pulse, count-down reached 0
//   wrapped      : one-cycle pulse, count-up rolled over all-9s
//   cmd_err      : one-cycle pulse, LOAD/START rejected while running
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10,
    parameter int unsigned PW       = 8
) (
    input  logic                clock,
    input  logic                reset,
    bcd_timer_ctrl_if.slave     cmd,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                tick,
    output logic                expired,
    output logic                wrapped,
    output logic                cmd_err
);

    localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [4*DIGITS-1:0] BCD_ONE  = 1;

    state_e        state_q, state_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic          dir_q, dir_d;
    logic          expired_q, expired_d;
    logic          wrapped_q, wrapped_d;
    logic          err_q, err_d;

    logic accept, is_load, is_start, is_stop, is_clear;
    logic load_ok, start_ok, preempt;
    logic count_zero, count_one, step_en;

    assign cmd.cmd_ready = ~reset;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign is_load       = accept & (cmd.cmd_op == OP_LOAD);
    assign is_start      = accept & (cmd.cmd_op == OP_START);
    assign is_stop       = accept & (cmd.cmd_op == OP_STOP);
    assign is_clear      = accept & (cmd.cmd_op == OP_CLEAR);
    assign load_ok       = is_load & (state_q != S_RUN);
    assign start_ok      = is_start & (state_q != S_RUN);
    // STOP/CLEAR win over a coincident tick; rejected LOAD/START do not.
    assign preempt       = is_stop | is_clear;

    assign count_zero = (count == '0);
    assign count_one  = (count == BCD_ONE);
    // Down count never steps below zero.
    assign step_en    = tick & ~(~dir_q & count_zero);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (is_clear || load_ok) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            state_d = (!cmd.cmd_up && count_zero) ? S_DONE : S_RUN;
        end else if (is_stop && state_q == S_RUN) begin
            state_d = S_PAUSE;
        end else if (tick && !dir_q && count_one) begin
            state_d = S_DONE;
        end
    end

    // Outputs; pulses are masked while reset is held.
    always_comb begin
        running = (state_q == S_RUN);
        tick    = (state_q == S_RUN) && (prescale_q == PRE_LAST) && !preempt && !reset;
        expired = expired_q & ~reset;
        wrapped = wrapped_q & ~reset;
        cmd_err = err_q & ~reset;
    end

    // Datapath next values
    always_comb begin
        prescale_d = prescale_q;
        if (is_clear || load_ok) begin
            prescale_d = '0;
        end else if (start_ok) begin
            // Resuming from PAUSE keeps the partial prescale period.
            if (state_q != S_PAUSE) begin
                prescale_d = '0;
            end
        end else if (state_q == S_RUN && !preempt) begin
            prescale_d = tick ? '0 : prescale_q + PW'(1);
        end
        dir_d     = start_ok ? cmd.cmd_up : dir_q;
        expired_d = (start_ok & ~cmd.cmd_up & count_zero) | (tick & ~dir_q & count_one);
        wrapped_d = dir_q & g_digit[DIGITS-1].cout;
        err_d     = (is_load | is_start) & (state_q == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_q <= '0;
            dir_q      <= 1'b0;
            expired_q  <= 1'b0;
            wrapped_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            dir_q      <= dir_d;
            expired_q  <= expired_d;
            wrapped_q  <= wrapped_d;
            err_q      <= err_d;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic cin;
        logic cout;
        if (i == 0) begin : g_cin
            assign cin = 1'b1;
        end else begin : g_cin
            assign cin = g_digit[i-1].cout;
        end

        bcd_digit u_digit (
            .clock (clock),
            .reset (reset),
            .load  (load_ok),
            .clr   (is_clear),
            .step  (step_en),
            .up    (dir_q),
            .cin   (cin),
            .data  (cmd.cmd_data[4*i +: 4]),
            .value (count[4*i +: 4]),
            .cout  (cout)
        );
    end

endmodule
